// File: rtl/hazard_ctrl_if.sv
// -----------------------------------------------------------------------------
// hazard_ctrl_if
// Signals between the pipeline and the hazard controller.
//   slave  : hazard controller side. Pipeline status comes in, stall/flush/hold
//            controls and the stall statistic go out.
//   master : pipeline side. It drives the status and receives the controls.
// Signal summary:
//   id_valid, id_rs1[2:0], id_rs2[2:0], id_use1, id_use2   ID stage operands
//   ex_valid, ex_rd[2:0], ex_load, ex_mult, br_taken       EX stage status
//   stall_if, stall_id, bubble_ex, flush_id, ex_hold       pipeline controls
//   stall_cnt[15:0]                                        stall-cycle count
// -----------------------------------------------------------------------------
interface hazard_ctrl_if;
  logic        id_valid;
  logic [2:0]  id_rs1;
  logic [2:0]  id_rs2;
  logic        id_use1;
  logic        id_use2;
  logic        ex_valid;
  logic [2:0]  ex_rd;
  logic        ex_load;
  logic        ex_mult;
  logic        br_taken;
  logic        stall_if;
  logic        stall_id;
  logic        bubble_ex;
  logic        flush_id;
  logic        ex_hold;
  logic [15:0] stall_cnt;

  modport slave (
    input  id_valid, id_rs1, id_rs2, id_use1, id_use2,
    input  ex_valid, ex_rd, ex_load, ex_mult, br_taken,
    output stall_if, stall_id, bubble_ex, flush_id, ex_hold, stall_cnt
  );

  modport master (
    output id_valid, id_rs1, id_rs2, id_use1, id_use2,
    output ex_valid, ex_rd, ex_load, ex_mult, br_taken,
    input  stall_if, stall_id, bubble_ex, flush_id, ex_hold, stall_cnt
  );
endinterface

// File: rtl/hazard_ctrl.sv
// -----------------------------------------------------------------------------
// hazard_ctrl
// Pipeline hazard controller: load-use stalls, multi-cycle EX holds and
// taken-branch flushes for a short in-order pipeline.
//
// Ports:
//   clk    in   rising-edge clock
//   rst_n  in   asynchronous active-low reset
//   bus    hazard_ctrl_if.slave (pipeline status in, controls out)
//
// Parameters:
//   MULT_CYCLES   total EX occupancy of a multi-cycle op (2..15)
//   FLUSH_CYCLES  total cycles flush_id is held after a taken branch (1..15)
//
// Build option:
//   HAZARD_STATS_EN  when defined, stall_cnt counts cycles with stall_if high
//                    (saturating). When undefined, stall_cnt is tied to 0 and
//                    no counter register is built.
//
// States:
//   state     | meaning
//   ----------+----------------------------------------------------------
//   RUN       | normal flow; branch / mult / load-use events are decoded
//   MULT_WAIT | multi-cycle op occupies EX; stall front end, hold EX
//   FLUSH     | remaining cycles of a taken-branch flush of IF-ID
// -----------------------------------------------------------------------------
module hazard_ctrl #(
  parameter int MULT_CYCLES  = 4,
  parameter int FLUSH_CYCLES = 2
) (
  input  logic          clk,
  input  logic          rst_n,
  hazard_ctrl_if.slave  bus
);

  typedef enum logic [1:0] {
    RUN       = 2'd0,
    MULT_WAIT = 2'd1,
    FLUSH     = 2'd2
  } state_e;

  // The cycle that detects the event is itself the first cycle of the
  // sequence, so the counter is loaded with the remaining count minus one
  // and the state is left on the cycle where it reads zero.
  localparam logic [3:0] MULT_LOAD  = 4'(MULT_CYCLES - 2);
  localparam logic [3:0] FLUSH_LOAD = 4'(FLUSH_CYCLES - 2);

  state_e     state_q, state_d;
  logic [3:0] cnt_q, cnt_d;

  logic load_use;
  logic stall_if_d;
  logic stall_id_d;
  logic bubble_ex_d;
  logic flush_id_d;
  logic ex_hold_d;

  always_comb begin
    load_use = bus.ex_valid && bus.ex_load && bus.id_valid &&
               ((bus.id_use1 && (bus.id_rs1 == bus.ex_rd)) ||
                (bus.id_use2 && (bus.id_rs2 == bus.ex_rd)));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= RUN;
      cnt_q   <= 4'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    stall_if_d  = 1'b0;
    stall_id_d  = 1'b0;
    bubble_ex_d = 1'b0;
    flush_id_d  = 1'b0;
    ex_hold_d   = 1'b0;

    unique case (state_q)
      RUN: begin
        // Priority: branch beats mult beats load-use.
        if (bus.ex_valid && bus.br_taken) begin
          flush_id_d  = 1'b1;
          bubble_ex_d = 1'b1;
          if (FLUSH_CYCLES > 1) begin
            cnt_d   = FLUSH_LOAD;
            state_d = FLUSH;
          end
        end else if (bus.ex_valid && bus.ex_mult) begin
          stall_if_d = 1'b1;
          stall_id_d = 1'b1;
          ex_hold_d  = 1'b1;
          cnt_d      = MULT_LOAD;
          state_d    = MULT_WAIT;
        end else if (load_use) begin
          stall_if_d  = 1'b1;
          stall_id_d  = 1'b1;
          bubble_ex_d = 1'b1;
        end
      end

      MULT_WAIT: begin
        stall_if_d = 1'b1;
        stall_id_d = 1'b1;
        ex_hold_d  = 1'b1;
        if (cnt_q == 4'd0) begin
          state_d = RUN;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end

      FLUSH: begin
        flush_id_d = 1'b1;
        if (cnt_q == 4'd0) begin
          state_d = RUN;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end

      default: begin
        state_d = RUN;
        cnt_d   = 4'd0;
      end
    endcase
  end

  assign bus.stall_if  = stall_if_d;
  assign bus.stall_id  = stall_id_d;
  assign bus.bubble_ex = bubble_ex_d;
  assign bus.flush_id  = flush_id_d;
  assign bus.ex_hold   = ex_hold_d;

`ifdef HAZARD_STATS_EN
  logic [15:0] stall_cnt_q, stall_cnt_d;

  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if (stall_if_d && (stall_cnt_q != 16'hFFFF)) begin
      stall_cnt_d = stall_cnt_q + 16'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_cnt_q <= 16'd0;
    end else begin
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign bus.stall_cnt = stall_cnt_q;
`else
  assign bus.stall_cnt = 16'd0;
`endif

endmodule

// File: tb/tb_hazard_ctrl.sv
module tb_hazard_ctrl;
  localparam int MC = 4;
  localparam int FC = 2;
`ifdef HAZARD_STATS_EN
  localparam bit STATS = 1'b1;
`else
  localparam bit STATS = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst_n = 1'b0;

  hazard_ctrl_if bus();

  hazard_ctrl #(.MULT_CYCLES(MC), .FLUSH_CYCLES(FC)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  // Reference model: cycles of the current sequence still to come after
  // the present cycle, plus the expected statistic.
  int mult_left  = 0;
  int flush_left = 0;
  int model_cnt  = 0;
  logic e_sif, e_sid, e_bub, e_fl, e_hold;

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic bit lu_hazard();
    return bus.ex_valid && bus.ex_load && bus.id_valid &&
           ((bus.id_use1 && bus.id_rs1 == bus.ex_rd) ||
            (bus.id_use2 && bus.id_rs2 == bus.ex_rd));
  endfunction

  task automatic model_eval();
    {e_sif, e_sid, e_bub, e_fl, e_hold} = 5'b0;
    if (mult_left > 0) begin
      e_sif = 1; e_sid = 1; e_hold = 1;
    end else if (flush_left > 0) begin
      e_fl = 1;
    end else if (bus.ex_valid && bus.br_taken) begin
      e_fl = 1; e_bub = 1;
    end else if (bus.ex_valid && bus.ex_mult) begin
      e_sif = 1; e_sid = 1; e_hold = 1;
    end else if (lu_hazard()) begin
      e_sif = 1; e_sid = 1; e_bub = 1;
    end
  endtask

  task automatic model_adv();
    if (STATS && e_sif && model_cnt < 65535) model_cnt++;
    if (mult_left > 0) mult_left--;
    else if (flush_left > 0) flush_left--;
    else if (bus.ex_valid && bus.br_taken) flush_left = FC - 1;
    else if (bus.ex_valid && bus.ex_mult) mult_left = MC - 1;
  endtask

  task automatic model_reset();
    mult_left = 0; flush_left = 0; model_cnt = 0;
  endtask

  task automatic set_idle();
    bus.id_valid = 0; bus.id_rs1 = 0; bus.id_rs2 = 0; bus.id_use1 = 0; bus.id_use2 = 0;
    bus.ex_valid = 0; bus.ex_rd = 0; bus.ex_load = 0; bus.ex_mult = 0; bus.br_taken = 0;
  endtask

  // Inputs are set just after a rising edge; outputs checked at the falling edge.
  task automatic step(input string tag);
    @(negedge clk);
    model_eval();
    chk({tag, ".stall_if"},  {15'd0, bus.stall_if},  {15'd0, e_sif});
    chk({tag, ".stall_id"},  {15'd0, bus.stall_id},  {15'd0, e_sid});
    chk({tag, ".bubble_ex"}, {15'd0, bus.bubble_ex}, {15'd0, e_bub});
    chk({tag, ".flush_id"},  {15'd0, bus.flush_id},  {15'd0, e_fl});
    chk({tag, ".ex_hold"},   {15'd0, bus.ex_hold},   {15'd0, e_hold});
    chk({tag, ".stall_cnt"}, bus.stall_cnt, 16'(model_cnt));
    @(posedge clk);
    model_adv();
    #1;
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, ".ctl"}, {11'd0, bus.stall_if, bus.stall_id, bus.bubble_ex,
                        bus.flush_id, bus.ex_hold}, 16'd0);
    chk({tag, ".stall_cnt"}, bus.stall_cnt, 16'd0);
  endtask

  task automatic load_use_setup(input logic [2:0] rs2);
    set_idle();
    bus.ex_valid = 1; bus.ex_load = 1; bus.ex_rd = 3'd3;
    bus.id_valid = 1; bus.id_use2 = 1; bus.id_rs2 = rs2; bus.id_rs1 = 3'd7;
  endtask

  initial begin
    set_idle();
    rst_n = 0;
    #1;
    chk_all_zero("reset");
    #10 rst_n = 1;
    @(posedge clk); #1;
    step("idle");

    // Load-use hit, then miss on rs2.
    load_use_setup(3'd3); step("lu_hit");
    set_idle();           step("lu_after");
    load_use_setup(3'd4); step("lu_miss");

    // Multi-cycle op: 4 held cycles then release.
    set_idle(); bus.ex_valid = 1; bus.ex_mult = 1; step("mult_c0");
    set_idle(); bus.ex_valid = 1;
    bus.br_taken = 1; step("mult_c1_ign_br");
    set_idle(); load_use_setup(3'd3); step("mult_c2_ign_lu");
    set_idle(); step("mult_c3");
    step("mult_done");

    // Taken branch: flush two cycles, bubble first cycle only.
    bus.ex_valid = 1; bus.br_taken = 1; step("br_c0");
    set_idle(); step("br_c1");
    step("br_done");

    // Branch + mult + load-use together: branch flush only.
    load_use_setup(3'd3); bus.ex_mult = 1; bus.br_taken = 1; step("prio_c0");
    set_idle(); step("prio_c1");
    step("prio_done");

    // Mult + load-use together: mult wins.
    load_use_setup(3'd3); bus.ex_mult = 1; step("mult_lu_c0");
    set_idle(); repeat (MC) step("mult_lu_tail");

    // Reset in the 2nd MULT_WAIT cycle.
    set_idle(); bus.ex_valid = 1; bus.ex_mult = 1; step("rst_mult_c0");
    set_idle(); step("rst_mult_c1");
    rst_n = 0;
    #1;
    chk_all_zero("rst_mid_mult");
    model_reset();
    #2 rst_n = 1;
    @(posedge clk); #1;
    chk_all_zero("rst_release");
    step("rst_after1");
    step("rst_after2");

    // Reset mid-flush.
    bus.ex_valid = 1; bus.br_taken = 1; step("rst_br_c0");
    set_idle();
    rst_n = 0;
    #1;
    chk_all_zero("rst_mid_flush");
    model_reset();
    #2 rst_n = 1;
    @(posedge clk); #1;
    step("rst_br_after");

    // Statistic: one mult plus one load-use stall.
    set_idle(); bus.ex_valid = 1; bus.ex_mult = 1; step("st_mult");
    set_idle(); repeat (MC - 1) step("st_mult_tail");
    load_use_setup(3'd3); step("st_lu");
    set_idle(); step("st_idle");
    chk("stats_total", bus.stall_cnt, STATS ? 16'd5 : 16'd0);

    // Randomized traffic against the model.
    for (int i = 0; i < 400; i++) begin
      bus.id_valid = ($urandom_range(0, 3) != 0);
      bus.id_rs1   = 3'($urandom_range(0, 3));
      bus.id_rs2   = 3'($urandom_range(0, 3));
      bus.id_use1  = 1'($urandom_range(0, 1));
      bus.id_use2  = 1'($urandom_range(0, 1));
      bus.ex_valid = ($urandom_range(0, 3) != 0);
      bus.ex_rd    = 3'($urandom_range(0, 3));
      bus.ex_load  = 1'($urandom_range(0, 1));
      bus.ex_mult  = ($urandom_range(0, 7) == 0);
      bus.br_taken = ($urandom_range(0, 7) == 0);
      step("rand");
    end

    set_idle();
    repeat (MC + FC) step("drain");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
